// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: state geometry, FSM encoding, rotation pairs,
// round constants and the inverse S-box used by the inverse permutation.
package ascon_pkg;

  localparam int ROUNDS_MAX = 12;
  localparam int WORD_W     = 64;
  localparam int STATE_W    = 5 * WORD_W;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Rotation pairs of the linear layer; element k belongs to word xk.
  localparam logic [4:0][5:0] ROT1 = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
  localparam logic [4:0][5:0] ROT2 = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

  // Saturate a requested round count to the permutation maximum.
  function automatic logic [CNT_W-1:0] sat_rounds(input logic [CNT_W-1:0] r);
    if (r > CNT_W'(ROUNDS_MAX)) return CNT_W'(ROUNDS_MAX);
    return r;
  endfunction

  // Round constant for round index r (0..11), added to word x2.
  function automatic logic [WORD_W-1:0] round_const(input logic [CNT_W-1:0] r);
    return {56'h0, 4'hF - r, r};
  endfunction

  // 64-bit rotate right.
  function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] x,
                                               input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

  // Inverse of x ^ (x >>> r1) ^ (x >>> r2): since Sigma^64 is the identity,
  // Sigma^-1 = Sigma^63 = product of Sigma^(2^k), and squaring in the
  // rotation ring just doubles the rotation amounts.
  function automatic logic [WORD_W-1:0] inv_sigma(input logic [WORD_W-1:0] x,
                                                  input logic [5:0] r1,
                                                  input logic [5:0] r2);
    logic [WORD_W-1:0] y;
    logic [5:0]        s1;
    logic [5:0]        s2;
    y = x;
    for (int k = 0; k < 6; k++) begin
      s1 = r1 << k;
      s2 = r2 << k;
      y  = y ^ rotr64(y, s1) ^ rotr64(y, s2);
    end
    return y;
  endfunction

  // Inverse 5-bit S-box, x0 bit as MSB of the column value.
  function automatic logic [4:0] inv_sbox(input logic [4:0] v);
    case (v)
      5'h00: return 5'h14;
      5'h01: return 5'h1a;
      5'h02: return 5'h07;
      5'h03: return 5'h0d;
      5'h04: return 5'h00;
      5'h05: return 5'h09;
      5'h06: return 5'h0e;
      5'h07: return 5'h12;
      5'h08: return 5'h0a;
      5'h09: return 5'h06;
      5'h0a: return 5'h1d;
      5'h0b: return 5'h01;
      5'h0c: return 5'h19;
      5'h0d: return 5'h15;
      5'h0e: return 5'h13;
      5'h0f: return 5'h1e;
      5'h10: return 5'h18;
      5'h11: return 5'h16;
      5'h12: return 5'h0b;
      5'h13: return 5'h11;
      5'h14: return 5'h03;
      5'h15: return 5'h05;
      5'h16: return 5'h1c;
      5'h17: return 5'h1f;
      5'h18: return 5'h17;
      5'h19: return 5'h1b;
      5'h1a: return 5'h04;
      5'h1b: return 5'h08;
      5'h1c: return 5'h0f;
      5'h1d: return 5'h0c;
      5'h1e: return 5'h10;
      default: return 5'h02;
    endcase
  endfunction

endpackage

// File: rtl/ascon_inv_round.sv
// One inverse ASCON round, purely combinational: inverse linear layer,
// inverse S-box per bit column, then removal of the round constant.
module ascon_inv_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [CNT_W-1:0]   a,
  input  logic [CNT_W-1:0]   i,
  output logic [STATE_W-1:0] result
);

  logic [WORD_W-1:0] lin [5];
  logic [WORD_W-1:0] sb  [5];
  logic [CNT_W-1:0]  ridx;

  // Forward round index being undone; i < a keeps this within 0..11.
  assign ridx = CNT_W'(ROUNDS_MAX) - a + i;

  // Undo diffusion word by word, then substitution column by column,
  // then strip the constant from x2.
  always_comb begin
    logic [4:0] v;
    logic [4:0] u;
    v = '0;
    u = '0;
    for (int k = 0; k < 5; k++) begin
      lin[k] = inv_sigma(state[STATE_W-1-WORD_W*k -: WORD_W], ROT1[k], ROT2[k]);
      sb[k]  = '0;
    end
    for (int j = 0; j < WORD_W; j++) begin
      v        = {lin[0][j], lin[1][j], lin[2][j], lin[3][j], lin[4][j]};
      u        = inv_sbox(v);
      sb[0][j] = u[4];
      sb[1][j] = u[3];
      sb[2][j] = u[2];
      sb[3][j] = u[1];
      sb[4][j] = u[0];
    end
    result = {sb[0], sb[1], sb[2] ^ round_const(ridx), sb[3], sb[4]};
  end

endmodule

// File: rtl/ascon_inv_permutation.sv
// Iterative inverse of the ASCON permutation p^a, one round per clock,
// with valid/ready handshakes on request and result.
module ascon_inv_permutation
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CNT_W-1:0]   rounds,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);

  fsm_e               fsm_q;
  fsm_e               fsm_d;
  logic               accept;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] round_out;
  logic [CNT_W-1:0]   a_q;
  logic [CNT_W-1:0]   i_q;
  logic [CNT_W-1:0]   a_new;

  assign a_new     = sat_rounds(rounds);
  assign state_out = state_q;

  ascon_inv_round u_round (
    .state  (state_q),
    .a      (a_q),
    .i      (i_q),
    .result (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_IDLE;
    else        fsm_q <= fsm_d;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    fsm_d     = fsm_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          fsm_d  = (a_new == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (i_q == '0) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State register and round counter: load on accept, one round per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      a_q     <= '0;
      i_q     <= '0;
    end else if (accept) begin
      state_q <= state_in;
      a_q     <= a_new;
      i_q     <= (a_new == '0) ? '0 : a_new - 1'b1;
    end else if (fsm_q == ST_RUN) begin
      state_q <= round_out;
      if (i_q != '0) i_q <= i_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// Bench for ascon_inv_permutation: states are pushed through a forward
// ASCON reference model, fed to the DUT, and must come back unchanged.
module tb_ascon_inv_permutation;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   rounds = '0;
  logic [319:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] state_out;
  logic         busy;

  int checks = 0;
  int failures = 0;

  int R1  [5]  = '{19, 61, 1, 10, 7};
  int R2  [5]  = '{28, 39, 6, 17, 41};
  int FSB [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                   30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};

  ascon_inv_permutation dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rounds    (rounds),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (64 - n));
  endfunction

  // Forward ASCON round with round index r: constant, S-box, diffusion.
  function automatic logic [319:0] fwd_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    int v;
    int u;
    for (int k = 0; k < 5; k++) begin
      x[k] = s[319-64*k -: 64];
      y[k] = '0;
    end
    x[2] = x[2] ^ 64'((15 - r) * 16 + r);
    for (int j = 0; j < 64; j++) begin
      v = 0;
      for (int k = 0; k < 5; k++) v = v * 2 + int'(x[k][j]);
      u = FSB[v];
      for (int k = 0; k < 5; k++) y[k][j] = u[4-k];
    end
    for (int k = 0; k < 5; k++) y[k] = y[k] ^ ror(y[k], R1[k]) ^ ror(y[k], R2[k]);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] fwd_perm(input logic [319:0] s, input int a);
    logic [319:0] t;
    t = s;
    for (int r = 12 - a; r < 12; r++) t = fwd_round(t, r);
    return t;
  endfunction

  function automatic int clampr(input int r);
    return (r > 12) ? 12 : r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  // Present one request at a negedge and hold it across the accept edge.
  task automatic send(input logic [3:0] r, input logic [319:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", {319'd0, in_ready}, 320'd1);
    in_valid = 1'b1;
    rounds   = r;
    state_in = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    lat = n;
  endtask

  // Full transaction: forward model, DUT inverse, compare, handshake out.
  task automatic do_op(input string tag, input logic [3:0] r, input logic [319:0] x);
    int a;
    int lat;
    a = clampr(int'(r));
    send(r, fwd_perm(x, a));
    wait_out(lat);
    chk({tag, "_latency"}, 320'(lat), 320'(a + 1));
    chk({tag, "_state"}, state_out, x);
    chk({tag, "_busy_done"}, {319'd0, busy}, 320'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {319'd0, in_ready}, 320'd1);
    chk({tag, "_out_valid_after"}, {319'd0, out_valid}, 320'd0);
  endtask

  initial begin
    logic [319:0] x;
    logic [319:0] pat;
    int lat;
    int hits;

    // Asynchronous reset values.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {319'd0, in_ready}, 320'd1);
    chk("rst_out_valid", {319'd0, out_valid}, 320'd0);
    chk("rst_busy", {319'd0, busy}, 320'd0);
    chk("rst_state_out", state_out, 320'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Zero state through twelve rounds.
    do_op("zero_r12", 4'd12, 320'd0);

    // Round trips on the repeating pattern.
    pat = {5{64'h0123456789abcdef}};
    do_op("pat_r6", 4'd6, pat);
    do_op("pat_r8", 4'd8, pat);

    // Zero rounds passes the state straight through; 15 clamps to 12.
    do_op("r0_pass", 4'd0, rand_state());
    do_op("r15_clamp", 4'd15, pat);

    // Single round undoing constant index 11 (c = 0x4b).
    do_op("single_r1", 4'd1, 320'd0);
    do_op("single_r1_rand", 4'd1, rand_state());

    // Backpressure: result held, second request ignored.
    x = rand_state();
    send(4'd4, fwd_perm(x, 4));
    wait_out(lat);
    chk("bp_latency", 320'(lat), 320'd5);
    in_valid = 1'b1;
    rounds   = 4'd3;
    state_in = rand_state();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {319'd0, out_valid}, 320'd1);
      chk("bp_state_out", state_out, x);
      chk("bp_in_ready", {319'd0, in_ready}, 320'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_in_ready_release", {319'd0, in_ready}, 320'd1);
    chk("bp_out_valid_release", {319'd0, out_valid}, 320'd0);
    repeat (3) @(negedge clk);
    chk("bp_ignored_not_busy", {319'd0, busy}, 320'd0);

    // Reset in the middle of a twelve-round run (i = 5).
    send(4'd12, fwd_perm(rand_state(), 12));
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {319'd0, out_valid}, 320'd0);
    chk("midrst_in_ready", {319'd0, in_ready}, 320'd1);
    chk("midrst_busy", {319'd0, busy}, 320'd0);
    chk("midrst_state_out", state_out, 320'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("midrst_no_out_valid", 320'(hits), 320'd0);
    do_op("after_rst", 4'd7, rand_state());

    // Randomized round trips.
    for (int t = 0; t < 10; t++) begin
      do_op("rand", 4'($urandom_range(0, 15)), rand_state());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_inv_permutation.md
# ascon_inv_permutation

Iterative inverse of the ASCON permutation p^a. It undoes a rounds of constant addition, substitution and linear diffusion on the 320-bit state, processing one round per clock. It sits beside the forward permutation datapath that adds round constant index 12-a+i to word x2. It serves decryption-side experiments and is the bench's round-trip checker for the forward core. Valid/ready handshakes are used on both ends.

## Interface
- Parameters: none; state width is fixed at 320 bits (5 × 64).
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  request carries a state to invert
- in_ready  output  1  block can accept a request
- rounds  input  4  a, the number of rounds to undo; sampled with the request
- state_in  input  320  x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0]
- out_valid  output  1  state_out holds the result
- out_ready  input  1  consumer takes the result
- state_out  output  320  inverted state, same word packing as state_in
- busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid:
  - load the state register from state_in.
  - a_reg = min(rounds, 12).
  - round counter i = a_reg - 1.
  - go to RUN. If a_reg = 0, go directly to DONE with the state unchanged.
- RUN: each cycle, apply inverse round i, then:
  - if i = 0, go to DONE;
  - otherwise decrement i.
- Inverse round i is applied in this order:
  1. Inverse linear layer per word: Σ_j^-1(x) = S5∘…∘S0(x), with S_k(x) = x ^ (x ⋙ (r1·2^k mod 64)) ^ (x ⋙ (r2·2^k mod 64)) for k = 0..5. The stages commute. This holds because Σ^64 = identity.
  2. Rotation pairs (r1, r2): x0 (19, 28), x1 (61, 39), x2 (1, 6), x3 (10, 17), x4 (7, 41).
  3. Inverse S-box on each bit column j. Input is {x0[j], x1[j], x2[j], x3[j], x4[j]} with x0 as MSB. Table for v = 0..31, hex: 14 1a 07 0d 00 09 0e 12 0a 06 1d 01 19 15 13 1e 18 16 0b 11 03 05 1c 1f 17 1b 04 08 0f 0c 10 02.
  4. Constant removal: x2 ^= c(12 - a_reg + i), with c(r) = {56'h0, (4'hF - r), r} for r = 0..11. This is a 4-bit unsigned index and always lies in 0..11.
- DONE: out_valid=1 and state_out = state register. On out_ready, return to IDLE.
- state_out is held stable, and only changes when the state register is loaded or updated.

## Timing
- Reset (asynchronous):
  - FSM goes to IDLE, with in_ready=1, out_valid=0, busy=0.
  - state_out = 0, i = 0, a_reg = 0.
- Latency:
  - Accept edge to out_valid is a_reg + 1 cycles.
  - With a_reg = 0, out_valid rises one cycle after the accept edge.
- in_ready is combinational from state only (IDLE). It does not depend on in_valid.
- out_valid is registered, and is not deasserted until out_ready is sampled high.
- Ignored inputs:
  - in_valid while busy is ignored; no queuing.
  - out_ready outside DONE is ignored.
- Back-to-back: the DONE→IDLE edge consumes one cycle. A new request is accepted no earlier than the cycle after the handoff, so throughput is one op per a_reg + 2 cycles.
- Reset asserted mid-RUN or mid-DONE discards the operation immediately; no output handshake occurs.
- rounds > 12 is clamped to 12. rounds and state_in are only sampled at the accept edge.

## Structure
- Shared package (ascon_pkg), holding items shared with the forward core:
  - ROUNDS_MAX = 12;
  - rotation-pair constants;
  - round-constant function c(r);
  - inverse S-box table.
- One combinational sub-module, ascon_inv_round:
  - inputs: state, a, i;
  - output: state after one inverse round.
- Top level: FSM, counter, state register.

## Test plan
- Zero state, rounds=12: run forward p^12 on the bench model, then feed the result in. state_out == 320'h0, out_valid exactly 13 cycles after accept.
- Round trip: state 320'h0123…(repeating 0123456789abcdef), rounds 6 and 8. Apply forward p^a, then inverse. Original is restored for both, with latencies 7 and 9.
- rounds=0 with state X: out_valid one cycle after accept, state_out == X. rounds=15 behaves identically to rounds=12.
- Backpressure: out_ready held 0 for 10 cycles. out_valid and state_out stable; in_ready=0; a second in_valid is ignored. Release out_ready, then in_ready=1 on the next cycle.
- Reset mid-RUN (i=5 of 12): rst_n low for 1 cycle. Outputs at reset values asynchronously, no out_valid; a fresh request then completes correctly.
- Single-round check: rounds=1, constant-only input. Invert the forward round (constant index 11, c=0x4b) and match the bench model bit-exact.
